// File: rtl/ex_md_pkg.sv
// Types shared by the execute stage and its iterative multiply/divide unit.
package ex_md_pkg;

    // Encoded exactly as the RV32M funct3 field
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

    localparam logic [31:0] BAAD_WORD = 32'hbaadbeef;

endpackage

// File: rtl/sys_defs.sv
// Shared decode encodings: ALU function codes and operand-mux selects
// produced by the decode stage and consumed by the execute stage.
package sys_defs;

    localparam logic [1:0] OPA_IS_REG = 2'd0;
    localparam logic [1:0] OPA_IS_PC  = 2'd1;
    localparam logic [1:0] OPA_IS_ZR  = 2'd2;

    localparam logic [1:0] OPB_IS_REG = 2'd0;
    localparam logic [1:0] OPB_IS_IMM = 2'd1;
    localparam logic [1:0] OPB_IS_4   = 2'd2;

    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_SUB  = 5'h01;
    localparam logic [4:0] ALU_SLT  = 5'h02;
    localparam logic [4:0] ALU_SLTU = 5'h03;
    localparam logic [4:0] ALU_AND  = 5'h04;
    localparam logic [4:0] ALU_OR   = 5'h05;
    localparam logic [4:0] ALU_XOR  = 5'h06;
    localparam logic [4:0] ALU_SLL  = 5'h07;
    localparam logic [4:0] ALU_SRL  = 5'h08;
    localparam logic [4:0] ALU_SRA  = 5'h09;

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative RV32M unit: shift-add multiplier (MUL_BITS/cycle) and restoring
// divider (1 bit/cycle). Result is held in DONE until the caller acks it.
module md_unit
    import ex_md_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_BITS      = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int MUL_ITERS = XLEN / MUL_BITS;
    localparam int CW        = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state, state_nxt;
    md_op_e    op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, mcand, pp, prod;
    logic [XLEN-1:0]   mplier, quo, rem, dvs, rem_nxt, q_fix, r_fix;
    logic [XLEN:0]     trial;
    logic              q_bit, neg_q, neg_r, fixed, early_q;
    logic              a_neg, b_neg, b_zero, ovf, early;
    logic [XLEN-1:0]   a_abs, b_abs;

    // Operand conditioning at start
    always_comb begin
        a_neg  = (md_op_e'(funct3) inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
        b_neg  = (md_op_e'(funct3) inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
        a_abs  = a_neg ? -a : a;
        b_abs  = b_neg ? -b : b;
        b_zero = (b == '0);
        ovf    = !funct3[0] && (a == SMIN) && (b == '1);
        early  = (DIV_EARLY_OUT != 0) && funct3[0] && (a < b);
    end

    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_BITS; j++)
            if (mplier[j]) pp = pp + (mcand << j);
        trial   = {rem, quo[XLEN-1]} - {1'b0, dvs};
        q_bit   = ~trial[XLEN];
        rem_nxt = q_bit ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = !funct3[2] ? MUL : (b_zero || ovf) ? DONE : DIV;
            MUL:  if (cnt == CW'(MUL_ITERS - 1)) state_nxt = DONE;
            DIV:  if (early_q || cnt == CW'(XLEN - 1)) state_nxt = DONE;
            DONE: if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op <= OP_MUL;   cnt <= '0;
            acc <= '0;      mcand <= '0;  mplier <= '0;
            quo <= '0;      rem <= '0;    dvs <= '0;
            neg_q <= 1'b0;  neg_r <= 1'b0;
            fixed <= 1'b0;  early_q <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op      <= md_op_e'(funct3);
                    cnt     <= '0;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    fixed   <= b_zero || ovf;
                    early_q <= early;
                    acc     <= '0;
                    mcand   <= {{XLEN{1'b0}}, a_abs};
                    mplier  <= b_abs;
                    dvs     <= b_abs;
                    // Special cases preload their final quotient/remainder
                    if (b_zero)     begin quo <= '1;    rem <= a;  end
                    else if (ovf)   begin quo <= a;     rem <= '0; end
                    else if (early) begin quo <= '0;    rem <= a;  end
                    else            begin quo <= a_abs; rem <= '0; end
                end
                MUL: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier >> MUL_BITS;
                    cnt    <= cnt + 1'b1;
                end
                DIV: if (!early_q) begin
                    quo <= {quo[XLEN-2:0], q_bit};
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod  = neg_q ? -acc : acc;
        q_fix = (neg_q && !fixed) ? -quo : quo;
        r_fix = (neg_r && !fixed) ? -rem : rem;
        case (op)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = q_fix;
            default:                      result = r_fix;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU/branch path plus iterative M-unit, with
// valid/ready on both sides and a registered result.
module ex_stage_md
    import ex_md_pkg::*;
    import sys_defs::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_BITS      = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] id_ex_PC,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [XLEN-1:0] id_ex_rega,
    input  logic [XLEN-1:0] id_ex_regb,
    input  logic [1:0]      id_ex_opa_select,
    input  logic [1:0]      id_ex_opb_select,
    input  logic [4:0]      id_ex_alu_func,
    input  logic [2:0]      id_ex_funct3,
    input  logic            id_ex_md,
    input  logic [XLEN-1:0] pc_add_opa,
    input  logic            uncond_branch,
    input  logic            cond_branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ex_result_out,
    output logic            ex_take_branch_out,
    output logic [XLEN-1:0] ex_target_PC_out
);
    localparam int SHW  = $clog2(XLEN);
    localparam int BW_N = (XLEN >= 32) ? XLEN / 32 : 1;
    localparam logic [32*BW_N-1:0] BAAD_REP = {BW_N{BAAD_WORD}};

    logic [XLEN-1:0] opa, opb, alu_result, md_result;
    logic [SHW-1:0]  shamt;
    logic            br_raw, take_branch;
    logic            md_busy, md_done, md_start, md_load, alu_fire;

    always_comb begin
        case (id_ex_opa_select)
            OPA_IS_REG: opa = id_ex_rega;
            OPA_IS_PC:  opa = id_ex_PC;
            OPA_IS_ZR:  opa = '0;
            default:    opa = '0;
        endcase
        case (id_ex_opb_select)
            OPB_IS_REG: opb = id_ex_regb;
            OPB_IS_IMM: opb = id_ex_imm;
            OPB_IS_4:   opb = XLEN'(4);
            default:    opb = '0;
        endcase
        shamt = opb[SHW-1:0];
        case (id_ex_alu_func)
            ALU_ADD:  alu_result = opa + opb;
            ALU_SUB:  alu_result = opa - opb;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, opa < opb};
            ALU_AND:  alu_result = opa & opb;
            ALU_OR:   alu_result = opa | opb;
            ALU_XOR:  alu_result = opa ^ opb;
            ALU_SLL:  alu_result = opa << shamt;
            ALU_SRL:  alu_result = opa >> shamt;
            ALU_SRA:  alu_result = $signed(opa) >>> shamt;
            default:  alu_result = XLEN'(BAAD_REP);
        endcase
    end

    always_comb begin
        case (id_ex_funct3[2:1])
            2'b00:   br_raw = (id_ex_rega == id_ex_regb);
            2'b10:   br_raw = $signed(id_ex_rega) < $signed(id_ex_regb);
            2'b11:   br_raw = id_ex_rega < id_ex_regb;
            default: br_raw = 1'b0;
        endcase
        take_branch = uncond_branch | (cond_branch & (br_raw ^ id_ex_funct3[0]));
    end

    assign in_ready = !rst && !md_busy && (!out_valid || out_ready);
    assign alu_fire = in_valid && in_ready && !id_ex_md && !flush;
    assign md_start = in_valid && in_ready && id_ex_md && !flush;
    // M result may only land when the output register is free or draining
    assign md_load  = md_done && (!out_valid || out_ready) && !flush;

    md_unit #(
        .XLEN(XLEN), .MUL_BITS(MUL_BITS), .DIV_EARLY_OUT(DIV_EARLY_OUT)
    ) u_md (
        .clk(clk), .rst(rst), .flush(flush), .start(md_start),
        .funct3(id_ex_funct3), .a(id_ex_rega), .b(id_ex_regb),
        .ack(md_load), .busy(md_busy), .done(md_done), .result(md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            ex_result_out      <= '0;
            ex_take_branch_out <= 1'b0;
            ex_target_PC_out   <= '0;
        end else begin
            if (flush)                   out_valid <= 1'b0;
            else if (alu_fire || md_load) out_valid <= 1'b1;
            else if (out_ready)          out_valid <= 1'b0;

            if (alu_fire) begin
                ex_result_out      <= alu_result;
                ex_take_branch_out <= take_branch;
                ex_target_PC_out   <= pc_add_opa + id_ex_imm;
            end else if (md_load) begin
                ex_result_out      <= md_result;
                ex_take_branch_out <= 1'b0;
                ex_target_PC_out   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed scoreboard bench for ex_stage_md (XLEN=32, MUL_BITS=2, early-out on).
module tb_ex_stage_md;
    import sys_defs::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] id_ex_PC, id_ex_imm, id_ex_rega, id_ex_regb, pc_add_opa;
    logic [1:0]  id_ex_opa_select, id_ex_opb_select;
    logic [4:0]  id_ex_alu_func;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_md, uncond_branch, cond_branch;
    logic [31:0] ex_result_out, ex_target_PC_out;
    logic        ex_take_branch_out;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        take;
        logic [31:0] tgt;
        logic        ct;
    } exp_t;
    exp_t sb_q[$];

    ex_stage_md #(.XLEN(32), .MUL_BITS(2), .DIV_EARLY_OUT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .id_ex_PC(id_ex_PC), .id_ex_imm(id_ex_imm), .id_ex_rega(id_ex_rega),
        .id_ex_regb(id_ex_regb), .id_ex_opa_select(id_ex_opa_select),
        .id_ex_opb_select(id_ex_opb_select), .id_ex_alu_func(id_ex_alu_func),
        .id_ex_funct3(id_ex_funct3), .id_ex_md(id_ex_md), .pc_add_opa(pc_add_opa),
        .uncond_branch(uncond_branch), .cond_branch(cond_branch),
        .out_valid(out_valid), .out_ready(out_ready), .ex_result_out(ex_result_out),
        .ex_take_branch_out(ex_take_branch_out), .ex_target_PC_out(ex_target_PC_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hffffffff;
                if (a == 32'h80000000 && b == 32'hffffffff) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hffffffff : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the output handshake is scored at the negedge, where inputs are stable
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            compared++;
            assert (sb_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_out: got %h expected none", ex_result_out);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({e.tag, "_res"}, ex_result_out, e.res);
                chk({e.tag, "_take"}, {31'b0, ex_take_branch_out}, {31'b0, e.take});
                if (e.ct) chk({e.tag, "_tgt"}, ex_target_PC_out, e.tgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < maxc) begin
            tick();
            lat++;
        end
    endtask

    task automatic issue(input string tag, input logic push, input logic md, input logic [2:0] f3,
                         input logic [4:0] fn, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] pca, input logic cb,
                         input logic ub, input logic [31:0] eres, input logic etake);
        exp_t e;
        id_ex_md = md; id_ex_funct3 = f3; id_ex_alu_func = fn;
        id_ex_opa_select = sa; id_ex_opb_select = sb;
        id_ex_rega = a; id_ex_regb = b; id_ex_PC = pc; id_ex_imm = imm;
        pc_add_opa = pca; cond_branch = cb; uncond_branch = ub;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        e.tag = tag; e.res = eres; e.take = etake; e.tgt = pca + imm; e.ct = !md;
        if (push) sb_q.push_back(e);
        tick();
        in_valid = 1'b0; cond_branch = 1'b0; uncond_branch = 1'b0;
    endtask

    logic [2:0]  mf3  [12] = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] ma   [12] = '{32'h80000000, 32'hffffffff, 32'd7, 32'hffffffff, 32'hfffffff9, 32'hfffffff9,
                               32'd123, 32'hffffff85, 32'h80000000, 32'h80000000, 32'd100, 32'd100};
    logic [31:0] mb   [12] = '{32'h80000000, 32'hffffffff, 32'hfffffffd, 32'hffffffff, 32'd2, 32'd2,
                               32'd0, 32'd0, 32'hffffffff, 32'hffffffff, 32'd7, 32'd7};
    int          mlat [12] = '{18, 18, 18, 18, 34, 34, 2, 2, 2, 2, 34, 34};

    initial begin
        int  lat;
        logic seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        id_ex_PC = '0; id_ex_imm = '0; id_ex_rega = '0; id_ex_regb = '0; pc_add_opa = '0;
        id_ex_opa_select = OPA_IS_REG; id_ex_opb_select = OPB_IS_REG;
        id_ex_alu_func = ALU_ADD; id_ex_funct3 = '0; id_ex_md = 1'b0;
        uncond_branch = 1'b0; cond_branch = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", ex_result_out, 32'd0);
        chk("rst_take", {31'b0, ex_take_branch_out}, 32'd0);
        chk("rst_target", ex_target_PC_out, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ALU path
        issue("add", 1, 0, 3'd0, ALU_ADD, OPA_IS_REG, OPB_IS_REG, 32'd7, 32'd5, 0, 0, 0, 0, 0, 32'd12, 0);
        chk("add_out_valid_t1", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++)
            issue($sformatf("b2b%0d", i), 1, 0, 3'd0, ALU_ADD, OPA_IS_REG, OPB_IS_IMM,
                  32'd100 * i, 0, 0, 32'd3 + i, 32'h40, 0, 0, 32'd100 * i + 32'd3 + i, 0);
        issue("blt", 1, 0, 3'b100, ALU_ADD, OPA_IS_PC, OPB_IS_IMM, 32'hffffffff, 32'd1,
              32'h200, 32'h20, 32'h100, 1, 0, 32'h220, 1);
        issue("bge", 1, 0, 3'b101, ALU_ADD, OPA_IS_PC, OPB_IS_IMM, 32'hffffffff, 32'd1,
              32'h200, 32'h20, 32'h100, 1, 0, 32'h220, 0);
        issue("bltu", 1, 0, 3'b110, ALU_ADD, OPA_IS_PC, OPB_IS_IMM, 32'hffffffff, 32'd1,
              32'h200, 32'h20, 32'h100, 1, 0, 32'h220, 0);
        issue("jal_wrap", 1, 0, 3'b000, ALU_ADD, OPA_IS_PC, OPB_IS_4, 0, 0,
              32'h1000, 32'h20, 32'hfffffff0, 0, 1, 32'h1004, 1);
        issue("sub", 1, 0, 3'd0, ALU_SUB, OPA_IS_REG, OPB_IS_REG, 32'd5, 32'd7, 0, 0, 0, 0, 0, 32'hfffffffe, 0);
        issue("sra", 1, 0, 3'd0, ALU_SRA, OPA_IS_REG, OPB_IS_REG, 32'h80000000, 32'h24, 0, 0, 0, 0, 0, 32'hf8000000, 0);
        issue("sll", 1, 0, 3'd0, ALU_SLL, OPA_IS_REG, OPB_IS_REG, 32'd1, 32'd33, 0, 0, 0, 0, 0, 32'd2, 0);
        issue("slt", 1, 0, 3'd0, ALU_SLT, OPA_IS_REG, OPB_IS_REG, 32'hffffffff, 32'd1, 0, 0, 0, 0, 0, 32'd1, 0);
        issue("zr_imm", 1, 0, 3'd0, ALU_OR, OPA_IS_ZR, OPB_IS_IMM, 32'h55, 0, 0, 32'h0abc, 0, 0, 0, 32'h0abc, 0);
        issue("baad", 1, 0, 3'd0, 5'h1f, OPA_IS_REG, OPB_IS_REG, 32'd1, 32'd2, 0, 0, 0, 0, 0, 32'hbaadbeef, 0);
        tick();

        // M-extension path
        for (int i = 0; i < 12; i++) begin
            issue($sformatf("md%0d_f%0d", i, mf3[i]), 1, 1, mf3[i], ALU_ADD, OPA_IS_REG, OPB_IS_REG,
                  ma[i], mb[i], 0, 0, 0, 0, 0, md_ref(mf3[i], ma[i], mb[i]), 0);
            chk($sformatf("md%0d_busy_in_ready", i), {31'b0, in_ready}, 32'd0);
            wait_valid(mlat[i] + 4, lat);
            chk($sformatf("md%0d_latency", i), lat, mlat[i]);
        end
        tick();

        // Early-out DIVU held against back-pressure
        out_ready = 1'b0;
        issue("divu_hold", 1, 1, 3'd5, ALU_ADD, OPA_IS_REG, OPB_IS_REG, 32'd5, 32'd9, 0, 0, 0, 0, 0, 32'd0, 0);
        wait_valid(8, lat);
        chk("divu_early_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("hold%0d_result", i), ex_result_out, 32'd0);
            chk($sformatf("hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Flush a DIV at iteration 10 together with a presented ADD
        issue("div_flushed", 0, 1, 3'd4, ALU_ADD, OPA_IS_REG, OPB_IS_REG, 32'hfffffff9, 32'd2, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) tick();
        flush = 1'b1; in_valid = 1'b1; id_ex_md = 1'b0; id_ex_alu_func = ALU_ADD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= (out_valid !== 1'b0);
            tick();
        end
        chk("flush_no_result", {31'b0, seen}, 32'd0);
        issue("add_after_flush", 1, 0, 3'd0, ALU_ADD, OPA_IS_REG, OPB_IS_REG, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h30, 0);
        chk("add_after_flush_valid", {31'b0, out_valid}, 32'd1);
        tick();

        // Reset pulse in the middle of a MULH
        issue("mulh_reset", 0, 1, 3'd1, ALU_ADD, OPA_IS_REG, OPB_IS_REG, 32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", ex_result_out, 32'd0);
        chk("mid_rst_take", {31'b0, ex_take_branch_out}, 32'd0);
        chk("mid_rst_target", ex_target_PC_out, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            seen |= (out_valid !== 1'b0);
            tick();
        end
        chk("rst_no_partial", {31'b0, seen}, 32'd0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised successor to the single-cycle execute stage.
- Keeps the ALU and branch resolution path.
- Adds an iterative multiply/divide unit (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Adds valid/ready handshakes on both sides and a registered output, so the stage can stall the decode/issue stage and absorb writeback back-pressure.
- Sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
- XLEN, 32, datapath width; must be even and ≥ 8.
- MUL_BITS, 2, multiplier bits retired per cycle; must divide XLEN; legal values 1, 2, 4.
- DIV_EARLY_OUT, 1, when 1, DIVU/REMU with dividend < divisor completes after 1 iteration cycle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill in-flight op and output register (branch mispredict / exception)
- in_valid  in  1  ID/EX carries a valid instruction
- in_ready  out  1  stage can accept this cycle
- id_ex_PC  in  XLEN  instruction PC
- id_ex_imm  in  XLEN  immediate
- id_ex_rega / id_ex_regb  in  XLEN  register operands
- id_ex_opa_select / id_ex_opb_select  in  2  operand mux selects (PC/ZR/REG; IMM/4/REG)
- id_ex_alu_func  in  5  ALU function code
- id_ex_funct3  in  3  branch condition or M-op select
- id_ex_md  in  1  instruction is an M-extension op
- pc_add_opa  in  XLEN  branch target base
- uncond_branch / cond_branch  in  1  branch class
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts result
- ex_result_out  out  XLEN  ALU or M-unit result
- ex_take_branch_out  out  1  branch taken (qualified by out_valid)
- ex_target_PC_out  out  XLEN  pc_add_opa + imm, registered

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0; ex_result_out=0; ex_take_branch_out=0; ex_target_PC_out=0; in_ready=0 while rst is high, then 1 from the first cycle after deassertion.
- Accept: in_valid & in_ready at edge T.
- Handshake:
  - in_ready = (state==IDLE) & (~out_valid | out_ready).
  - Output is held stable while out_valid & ~out_ready.
  - out_valid drops after the out_ready handshake unless a new result is loaded on the same edge.
- Non-M op (id_ex_md=0):
  - ALU/branch computed combinationally as in the single-cycle stage: SLL/SRL/SRA use opb[log2(XLEN)-1:0]; undefined alu_func gives result {XLEN/32 copies of 32'hbaadbeef}, truncated.
  - Branch condition on rega/regb by funct3[2:1] (00 EQ, 10 LT signed, 11 LTU, 01 false), inverted if funct3[0].
  - take_branch = uncond | (cond & brcond).
  - Registered at T; out_valid=1 from T+1 (latency 1).
- M op (id_ex_md=1): take_branch forced 0. FSM states IDLE → MUL or DIV → DONE → IDLE.
  - MUL: operands captured as absolute values with sign flags per funct3 (MULHSU: rs1 signed, rs2 unsigned); shift-add MUL_BITS per cycle over XLEN/MUL_BITS cycles into a 2·XLEN accumulator; DONE applies sign negation and selects the low (MUL) or high half.
    - Latency: out_valid at T+2+XLEN/MUL_BITS.
  - DIV: restoring divider, 1 quotient bit per cycle, XLEN cycles; DONE fixes signs (quotient negative iff signs differ; remainder takes dividend sign).
    - Latency: T+2+XLEN.
    - With DIV_EARLY_OUT=1, early-out cases: T+3.
  - Divide by zero: no iteration, straight to DONE. Quotient = all ones; remainder = dividend. Latency T+2.
  - Signed overflow (−2^(XLEN−1) / −1): straight to DONE. Quotient = dividend; remainder = 0. Latency T+2.
  - DONE loads the output register; if the output register is still occupied and not draining, the FSM stays in DONE.
- flush:
  - Synchronous. Next edge: state IDLE, out_valid=0, iteration counter cleared.
  - Any input presented in the same cycle is dropped.
  - flush has priority over out_ready and in_valid.
- Reset mid-operation: immediate return to reset values; no partial result is emitted.
- Widths: all arithmetic modulo 2^XLEN. Target PC adder wraps silently.

Decomposition:
- Shared package ex_md_pkg: md_op_e enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU mapped to funct3), md_state_e (IDLE, MUL, DIV, DONE), BAAD_WORD constant.
- ALU function and opA/opB select codes stay in sys_defs.
- One sub-module: md_unit (iterative mul/div with start/busy/done). The combinational ALU stays in this block.

Test Plan:
- ADD rega=7, regb=5, out_ready=1 → out_valid at T+1, result 12, take_branch 0; back-to-back ADDs sustain 1 op/cycle.
- BLT rega=0xFFFFFFFF, regb=1, cond_branch=1, pc_add_opa=0x100, imm=0x20 → take_branch 1, target 0x120; BGE same operands → 0.
- MULH rega=0x80000000, regb=0x80000000 (XLEN=32, MUL_BITS=2) → in_ready low, result 0x40000000 at T+18; MULHSU rega=−1, regb=0xFFFFFFFF → 0xFFFFFFFF.
- DIV rega=−7, regb=2 → quotient −3 (0xFFFFFFFD) at T+34; REM → 0xFFFFFFFF; DIVU x/0 → 0xFFFFFFFF at T+2; DIV 0x80000000/−1 → 0x80000000.
- DIVU 5/0x9 with out_ready=0 held 5 cycles → result 0 held stable, in_ready=0 until the out_ready handshake.
- flush asserted at iteration 10 of a DIV → out_valid never rises for it, in_ready=1 next cycle; a following ADD completes normally; rst pulse mid-MUL → all outputs 0 immediately.
